// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle controller and its datapath and memory.
// The controller takes the slave view; the datapath/bench takes the master view.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        branch_cond;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  ALUop;
    logic [2:0]  state;
    logic        trap;
    logic [31:0] instret;

    modport slave (
        input  opcode, branch_cond, mem_ready,
        output mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
               alu_src_a, alu_src_b, ALUop, state, trap, instret
    );

    modport master (
        output opcode, branch_cond, mem_ready,
        input  mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
               alu_src_a, alu_src_b, ALUop, state, trap, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory
// wait watchdog that parks the core in a sticky TRAP state.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 16   // legal range 1..255
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC
    } iclass_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      r_state, w_next;
    iclass_t     r_class, w_dec_class;
    logic        w_dec_legal;
    logic [7:0]  r_wait, w_wait_next;
    logic [31:0] r_instret;
    logic        w_retire, w_timeout;

    logic       w_mem_req, w_mem_we, w_mem_sel, w_ir_we, w_pc_we, w_reg_we;
    logic       w_alu_src_b, w_trap;
    logic [1:0] w_pc_src, w_wb_sel, w_alu_src_a, w_aluop;

    always_comb begin
        w_dec_class = C_R;
        w_dec_legal = 1'b1;
        case (bus.opcode)
            7'b0110011: w_dec_class = C_R;
            7'b0010011: w_dec_class = C_I;
            7'b0000011: w_dec_class = C_LOAD;
            7'b0100011: w_dec_class = C_STORE;
            7'b1100011: w_dec_class = C_BR;
            7'b1101111: w_dec_class = C_JAL;
            7'b1100111: w_dec_class = C_JALR;
            7'b0110111: w_dec_class = C_LUI;
            7'b0010111: w_dec_class = C_AUIPC;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    // Once the watchdog has expired the request is dropped and mem_ready no longer matters.
    assign w_timeout = (r_wait == WAIT_LIMIT);

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_sel   = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = 2'b00;
        w_reg_we    = 1'b0;
        w_wb_sel    = 2'b00;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 1'b0;
        w_aluop     = 2'b00;
        w_trap      = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_timeout) begin
                    w_next = S_TRAP;
                end else begin
                    w_mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        w_ir_we = 1'b1;
                        w_next  = S_DECODE;
                    end
                end
            end
            S_DECODE: w_next = w_dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (r_class)
                    C_R:     w_aluop = 2'b10;
                    C_I: begin
                        w_alu_src_b = 1'b1;
                        w_aluop     = 2'b10;
                    end
                    C_LUI: begin
                        w_alu_src_a = 2'b10;
                        w_alu_src_b = 1'b1;
                    end
                    C_AUIPC, C_JAL: begin
                        w_alu_src_a = 2'b01;
                        w_alu_src_b = 1'b1;
                    end
                    C_BR: begin
                        w_aluop  = 2'b01;
                        w_pc_we  = 1'b1;
                        w_pc_src = bus.branch_cond ? 2'b01 : 2'b00;
                        w_retire = 1'b1;
                    end
                    default: w_alu_src_b = 1'b1;   // LOAD, STORE, JALR: rs1 + imm
                endcase
                if (r_class == C_BR)
                    w_next = S_FETCH;
                else if (r_class == C_LOAD || r_class == C_STORE)
                    w_next = S_MEM;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                if (w_timeout) begin
                    w_next = S_TRAP;
                end else begin
                    w_mem_req = 1'b1;
                    w_mem_sel = 1'b1;
                    w_mem_we  = (r_class == C_STORE);
                    if (bus.mem_ready) begin
                        if (r_class == C_STORE) begin
                            w_pc_we  = 1'b1;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                case (r_class)
                    C_LOAD: w_wb_sel = 2'b01;
                    C_JAL: begin
                        w_wb_sel = 2'b10;
                        w_pc_src = 2'b01;
                    end
                    C_JALR: begin
                        w_wb_sel = 2'b10;
                        w_pc_src = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_TRAP:  w_trap = 1'b1;
            default: w_next = S_TRAP;   // unused encodings are treated as a fault
        endcase
    end

    always_comb begin
        w_wait_next = 8'd0;
        if ((r_state == S_FETCH || r_state == S_MEM) && !w_timeout && !bus.mem_ready)
            w_wait_next = r_wait + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_class   <= C_R;
            r_wait    <= 8'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (r_state == S_DECODE)
                r_class <= w_dec_class;
            if (w_retire)
                r_instret <= r_instret + 32'd1;
        end
    end

    // Reset forces every strobe low even between clock edges.
    assign bus.mem_req   = w_mem_req & ~rst;
    assign bus.mem_we    = w_mem_we & ~rst;
    assign bus.mem_sel   = w_mem_sel & ~rst;
    assign bus.ir_we     = w_ir_we & ~rst;
    assign bus.pc_we     = w_pc_we & ~rst;
    assign bus.pc_src    = rst ? 2'b00 : w_pc_src;
    assign bus.reg_we    = w_reg_we & ~rst;
    assign bus.wb_sel    = rst ? 2'b00 : w_wb_sel;
    assign bus.alu_src_a = rst ? 2'b00 : w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b & ~rst;
    assign bus.ALUop     = rst ? 2'b00 : w_aluop;
    assign bus.trap      = w_trap & ~rst;
    assign bus.state     = r_state;
    assign bus.instret   = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control outputs; a monitor checks them.
module tb_multicycle_ctrl;
    localparam int MAX_WAIT = 16;
    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req;
        logic        mem_we;
        logic        mem_sel;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic [1:0]  alu_a;
        logic        alu_b;
        logic [1:0]  aluop;
        logic        trap;
        logic [31:0] instret;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       mem_ready;
        logic [6:0] opcode;
        logic       bc;
        obs_t       e;
        string      nm;
    } step_t;

    typedef struct {
        obs_t  e;
        string nm;
    } chk_t;

    logic clk = 1'b0;
    logic rst;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    step_t       steps[$];
    chk_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_instret = 32'd0;
    logic [6:0]  legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    always @(negedge clk) begin
        chk_t c;
        obs_t a;
        if (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            a = {bus.state, bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_we, bus.pc_we,
                 bus.pc_src, bus.reg_we, bus.wb_sel, bus.alu_src_a, bus.alu_src_b,
                 bus.ALUop, bus.trap, bus.instret};
            total++;
            if (a !== c.e) begin
                bad++;
                $display("FAIL %s t=%0t got state=%0d ctl=%h instret=%h exp state=%0d ctl=%h instret=%h",
                         c.nm, $time, a.state, a[47:32], a.instret,
                         c.e.state, c.e[47:32], c.e.instret);
            end
        end
    end

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            OP_R:     return K_R;
            OP_I:     return K_I;
            OP_LOAD:  return K_LOAD;
            OP_STORE: return K_STORE;
            OP_BR:    return K_BR;
            OP_JAL:   return K_JAL;
            OP_JALR:  return K_JALR;
            OP_LUI:   return K_LUI;
            OP_AUIPC: return K_AUIPC;
            default:  return -1;
        endcase
    endfunction

    // One cycle with random don't-care inputs and all-zero outputs except state/instret.
    function automatic step_t base(input string nm, input logic [2:0] st);
        step_t s;
        s.rst       = 1'b0;
        s.mem_ready = 1'($urandom);
        s.opcode    = 7'($urandom);
        s.bc        = 1'($urandom);
        s.e         = '0;
        s.e.state   = st;
        s.e.instret = m_instret;
        s.nm        = nm;
        return s;
    endfunction

    task automatic add_trap(input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s = base("trap", 3'd5);
            s.e.trap = 1'b1;
            steps.push_back(s);
        end
    endtask

    task automatic add_reset(input int n);
        step_t s;
        m_instret = 32'd0;
        for (int i = 0; i < n; i++) begin
            s = base("reset", 3'd0);
            s.rst = 1'b1;
            steps.push_back(s);
        end
    endtask

    task automatic add_mem_wait(input string nm, input int n, input bit store);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s = base(nm, 3'd3);
            s.mem_ready = 1'b0;
            s.e.mem_req = 1'b1;
            s.e.mem_sel = 1'b1;
            s.e.mem_we  = store;
            steps.push_back(s);
        end
    endtask

    // Expands one instruction into its cycle sequence from the class rules.
    task automatic gen_instr(input logic [6:0] op, input logic bc, input int fwait,
                             input int mwait, input int thold, output bit trapped);
        step_t s;
        int    k;
        k = cls_of(op);
        trapped = 1'b0;
        for (int i = 0; i < fwait && i < MAX_WAIT; i++) begin
            s = base("fetch_wait", 3'd0);
            s.mem_ready = 1'b0;
            s.e.mem_req = 1'b1;
            steps.push_back(s);
        end
        if (fwait >= MAX_WAIT) begin
            steps.push_back(base("fetch_timeout", 3'd0));
            add_trap(thold);
            trapped = 1'b1;
            return;
        end
        s = base("fetch", 3'd0);
        s.mem_ready = 1'b1;
        s.e.mem_req = 1'b1;
        s.e.ir_we   = 1'b1;
        steps.push_back(s);
        s = base("decode", 3'd1);
        s.opcode = op;
        steps.push_back(s);
        if (k < 0) begin
            add_trap(thold);
            trapped = 1'b1;
            return;
        end
        s = base("exec", 3'd2);
        case (k)
            K_R: s.e.aluop = 2'b10;
            K_I: begin
                s.e.alu_b = 1'b1;
                s.e.aluop = 2'b10;
            end
            K_LUI: begin
                s.e.alu_a = 2'b10;
                s.e.alu_b = 1'b1;
            end
            K_AUIPC, K_JAL: begin
                s.e.alu_a = 2'b01;
                s.e.alu_b = 1'b1;
            end
            K_BR: begin
                s.bc       = bc;
                s.e.aluop  = 2'b01;
                s.e.pc_we  = 1'b1;
                s.e.pc_src = {1'b0, bc};
            end
            default: s.e.alu_b = 1'b1;
        endcase
        steps.push_back(s);
        if (k == K_BR) begin
            m_instret++;
            return;
        end
        if (k == K_LOAD || k == K_STORE) begin
            add_mem_wait("mem_wait", (mwait < MAX_WAIT) ? mwait : MAX_WAIT, k == K_STORE);
            if (mwait >= MAX_WAIT) begin
                steps.push_back(base("mem_timeout", 3'd3));
                add_trap(thold);
                trapped = 1'b1;
                return;
            end
            s = base("mem", 3'd3);
            s.mem_ready = 1'b1;
            s.e.mem_req = 1'b1;
            s.e.mem_sel = 1'b1;
            s.e.mem_we  = (k == K_STORE);
            s.e.pc_we   = (k == K_STORE);
            steps.push_back(s);
            if (k == K_STORE) begin
                m_instret++;
                return;
            end
        end
        s = base("wb", 3'd4);
        s.e.reg_we = 1'b1;
        s.e.pc_we  = 1'b1;
        if (k == K_LOAD) s.e.wb_sel = 2'b01;
        if (k == K_JAL || k == K_JALR) s.e.wb_sel = 2'b10;
        if (k == K_JAL)  s.e.pc_src = 2'b01;
        if (k == K_JALR) s.e.pc_src = 2'b10;
        steps.push_back(s);
        m_instret++;
    endtask

    task automatic drive_one();
        step_t s;
        chk_t  c;
        s = steps.pop_front();
        @(posedge clk);
        #1;
        rst             = s.rst;
        bus.mem_ready   = s.mem_ready;
        bus.opcode      = s.opcode;
        bus.branch_cond = s.bc;
        c.e  = s.e;
        c.nm = s.nm;
        sb_q.push_back(c);
    endtask

    task automatic drive_all();
        while (steps.size() > 0) drive_one();
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return MAX_WAIT;
        if (r == 1) return MAX_WAIT - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit tr;
        rst             = 1'b1;
        bus.mem_ready   = 1'b0;
        bus.opcode      = 7'd0;
        bus.branch_cond = 1'b0;

        add_reset(2);                              drive_all();
        gen_instr(OP_R, 1'b0, 0, 0, 1, tr);        drive_all();
        gen_instr(OP_LOAD, 1'b0, 0, 2, 1, tr);     drive_all();
        gen_instr(OP_BR, 1'b1, 0, 0, 1, tr);       drive_all();
        gen_instr(OP_BR, 1'b0, 0, 0, 1, tr);       drive_all();
        gen_instr(OP_STORE, 1'b0, 1, 1, 1, tr);    drive_all();
        gen_instr(OP_I, 1'b0, 1, 0, 1, tr);        drive_all();
        gen_instr(OP_LUI, 1'b0, 0, 0, 1, tr);      drive_all();
        gen_instr(OP_AUIPC, 1'b0, 2, 0, 1, tr);    drive_all();
        gen_instr(OP_JALR, 1'b0, 0, 0, 1, tr);     drive_all();

        gen_instr(7'b1111111, 1'b0, 0, 0, 100, tr); drive_all();
        add_reset(2);                               drive_all();
        gen_instr(OP_R, 1'b0, MAX_WAIT, 0, 5, tr);  drive_all();
        add_reset(1);                               drive_all();
        gen_instr(OP_STORE, 1'b0, 0, MAX_WAIT, 5, tr); drive_all();
        add_reset(1);                               drive_all();
        gen_instr(OP_R, 1'b0, MAX_WAIT - 1, 0, 1, tr); drive_all();

        // Preload the retire counter just before JAL to exercise the wrap.
        m_instret = 32'hFFFF_FFFF;
        gen_instr(OP_JAL, 1'b0, 1, 0, 1, tr);
        drive_one();
        dut.r_instret = 32'hFFFF_FFFF;
        drive_all();
        gen_instr(OP_R, 1'b0, 0, 0, 1, tr);        drive_all();

        // Abort a load mid-MEM while the request is up.
        gen_instr(OP_LOAD, 1'b0, 0, 3, 1, tr);
        repeat (5) drive_one();
        steps.delete();
        add_reset(1);                              drive_all();
        gen_instr(OP_R, 1'b0, 0, 0, 1, tr);        drive_all();

        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            bit         trp;
            int         cut;
            if ($urandom_range(0, 19) == 0) begin
                do op = 7'($urandom); while (cls_of(op) >= 0);
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            gen_instr(op, 1'($urandom), pick_wait(), pick_wait(), $urandom_range(1, 4), trp);
            if (!trp && steps.size() > 1 && $urandom_range(0, 14) == 0) begin
                cut = $urandom_range(1, steps.size() - 1);
                repeat (cut) drive_one();
                steps.delete();
                add_reset(1 + $urandom_range(0, 1));
            end else if (trp) begin
                add_reset(1 + $urandom_range(0, 1));
            end
            drive_all();
        end

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
